// File: rtl/wide_imm_pkg.sv
// wide_imm_pkg: shared types and helpers for the wide immediate loader.
//   wil_state_t  : sequencer states (IDLE, STEP, DONE)
//   WIL_HW       : halfword width (16)
//   WIL_NSTEP    : halfwords per 64-bit constant (4)
//   hw_mask(k)   : 64-bit mask selecting halfword k
//   hw_sel(v,k)  : extract halfword k of v
//   next_nz(v,k) : {found, idx} of the lowest nonzero halfword of v with
//                  index above k (used only when WIDE_IMM_SKIP_ZERO_EN is set)
package wide_imm_pkg;

  localparam int WIL_HW    = 16;
  localparam int WIL_NSTEP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } wil_state_t;

  function automatic logic [63:0] hw_mask(input logic [1:0] k);
    return 64'h0000_0000_0000_FFFF << {k, 4'b0000};
  endfunction

  function automatic logic [15:0] hw_sel(input logic [63:0] v, input logic [1:0] k);
    return v[{k, 4'b0000} +: 16];
  endfunction

  function automatic logic [2:0] next_nz(input logic [63:0] v, input logic [1:0] k);
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    idx   = 2'd0;
    // Walk downwards so the last hit kept is the lowest qualifying index.
    for (int i = 3; i >= 1; i--) begin
      if ((2'(i) > k) && (hw_sel(v, 2'(i)) != 16'h0000)) begin
        found = 1'b1;
        idx   = 2'(i);
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/wide_imm_loader_hw_merge.sv
// hw_merge: combinational halfword merge into the accumulator.
//   acc      : current accumulator
//   mov_data : transposer output for this step
//   k        : halfword index being written
//   merged   : acc with halfword k replaced by mov_data's halfword k
// Only the selected halfword of mov_data is used; the transposer leaves the
// other bits undefined on MOVK steps.
module hw_merge
  import wide_imm_pkg::*;
(
  input  logic [63:0] acc,
  input  logic [63:0] mov_data,
  input  logic [1:0]  k,
  output logic [63:0] merged
);

  logic [63:0] mask_s;

  // Masked replace of one halfword.
  always_comb begin
    mask_s = hw_mask(k);
    merged = (acc & ~mask_s) | (mov_data & mask_s);
  end

endmodule

// File: rtl/wide_imm_loader.sv
// wide_imm_loader: builds a 64-bit constant by sequencing MOVZ/MOVK steps
// through an external halfword transposer and merging each result.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start_valid/ready     : request handshake; target sampled on accept
//   target                : constant to build
//   flush                 : synchronous abort back to IDLE, no done
//   mov_valid/fixed/shamt/clear : transposer operands (registered, 0 when idle)
//   mov_data              : transposer result, combinational from mov_*
//   busy                  : high in STEP and DONE
//   done                  : one-cycle completion pulse
//   result                : accumulator, valid when done is high
// Configuration macro: WIDE_IMM_SKIP_ZERO_EN -- when defined, MOVK steps for
// zero halfwords 1..3 are skipped (MOVZ already zeroed them).
module wide_imm_loader
  import wide_imm_pkg::*;
#(
  parameter int DW = 64,
  parameter int HW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [DW-1:0] target,
  input  logic          flush,
  output logic          mov_valid,
  output logic [HW-1:0] mov_fixed,
  output logic [1:0]    mov_shamt,
  output logic          mov_clear,
  input  logic [DW-1:0] mov_data,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result
);

  wil_state_t    state_q, state_d;
  logic [63:0]   tgt_q, tgt_d;
  logic [63:0]   acc_q, acc_d;
  logic [1:0]    k_q, k_d;
  logic          mov_valid_q, mov_valid_d;
  logic [15:0]   mov_fixed_q, mov_fixed_d;
  logic [1:0]    mov_shamt_q, mov_shamt_d;
  logic          mov_clear_q, mov_clear_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          accept_s;
  logic          nxt_found_s;
  logic [1:0]    nxt_k_s;
  logic [63:0]   merged_s;

  assign start_ready = (state_q == IDLE) & ~flush;
  assign accept_s    = start_valid & start_ready;

`ifdef WIDE_IMM_SKIP_ZERO_EN
  assign {nxt_found_s, nxt_k_s} = next_nz(tgt_q, k_q);
`else
  assign nxt_found_s = (k_q != 2'd3);
  assign nxt_k_s     = k_q + 2'd1;
`endif

  hw_merge u_merge (
    .acc      (acc_q),
    .mov_data (mov_data),
    .k        (k_q),
    .merged   (merged_s)
  );

  // Next-state, accumulator and registered output decode.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    k_d     = k_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = STEP;
          tgt_d   = target;
          k_d     = 2'd0;
          acc_d   = 64'd0;
        end else begin
          state_d = IDLE;
        end
      end
      STEP: begin
        if (flush) begin
          // Abort leaves the partial accumulator untouched.
          state_d = IDLE;
        end else begin
          acc_d = merged_s;
          if (nxt_found_s) begin
            k_d = nxt_k_s;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step.
    if (state_d == STEP) begin
      mov_valid_d = 1'b1;
      mov_fixed_d = hw_sel(tgt_d, k_d);
      mov_shamt_d = k_d;
      mov_clear_d = (k_d == 2'd0);
    end else begin
      mov_valid_d = 1'b0;
      mov_fixed_d = 16'h0000;
      mov_shamt_d = 2'd0;
      mov_clear_d = 1'b0;
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tgt_q       <= 64'd0;
      acc_q       <= 64'd0;
      k_q         <= 2'd0;
      mov_valid_q <= 1'b0;
      mov_fixed_q <= 16'h0000;
      mov_shamt_q <= 2'd0;
      mov_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      mov_valid_q <= mov_valid_d;
      mov_fixed_q <= mov_fixed_d;
      mov_shamt_q <= mov_shamt_d;
      mov_clear_q <= mov_clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mov_valid = mov_valid_q;
  assign mov_fixed = mov_fixed_q;
  assign mov_shamt = mov_shamt_q;
  assign mov_clear = mov_clear_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = acc_q;

endmodule

// File: tb/tb_wide_imm_loader.sv
// Self-checking bench for wide_imm_loader with a behavioural halfword
// transposer (MOVK steps return random bits outside the written halfword).
module tb_wide_imm_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [63:0] target;
  logic        flush;
  logic        mov_valid;
  logic [15:0] mov_fixed;
  logic [1:0]  mov_shamt;
  logic        mov_clear;
  logic [63:0] mov_data;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [63:0] garbage = 64'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wide_imm_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .target      (target),
    .flush       (flush),
    .mov_valid   (mov_valid),
    .mov_fixed   (mov_fixed),
    .mov_shamt   (mov_shamt),
    .mov_clear   (mov_clear),
    .mov_data    (mov_data),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  // Transposer: MOVZ zeroes everything else, MOVK leaves undefined junk.
  always_comb begin
    if (mov_clear) begin
      mov_data = 64'(mov_fixed) << (int'(mov_shamt) * 16);
    end else begin
      mov_data = garbage;
      mov_data[int'(mov_shamt) * 16 +: 16] = mov_fixed;
    end
  end

  always @(negedge clk) garbage = {$urandom, $urandom};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One request from the current cycle (N) through done and ready again.
  task automatic run_txn(input logic [63:0] t, input bit hold, input logic [63:0] nxt);
    int idx[4];
    int n;
    logic [15:0] exp_hw;
    n = 0;
    idx[0] = 0;
    n = 1;
    for (int h = 1; h < 4; h++) begin
`ifdef WIDE_IMM_SKIP_ZERO_EN
      if (((t >> (16 * h)) & 64'hFFFF) != 64'd0) begin
        idx[n] = h;
        n++;
      end
`else
      idx[n] = h;
      n++;
`endif
    end
    start_valid = 1'b1;
    target = t;
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL txn_ready got %b want 1", start_ready);
    end
    for (int i = 0; i < n; i++) begin
      tick;
      if (i == 0) begin
        if (hold) target = nxt;
        else start_valid = 1'b0;
      end
      exp_hw = 16'((t >> (16 * idx[i])) & 64'hFFFF);
      checks++;
      if ({mov_valid, mov_fixed, mov_shamt, mov_clear} !==
          {1'b1, exp_hw, 2'(idx[i]), (idx[i] == 0)}) begin
        errors++;
        $display("FAIL step%0d got v=%b f=%h s=%0d c=%b want v=1 f=%h s=%0d c=%b t=%h",
                 i, mov_valid, mov_fixed, mov_shamt, mov_clear, exp_hw, idx[i], (idx[i] == 0), t);
      end
      checks++;
      if ({busy, done, start_ready} !== 3'b100) begin
        errors++;
        $display("FAIL step%0d_flags got busy/done/ready=%b want 100", i, {busy, done, start_ready});
      end
    end
    tick;
    checks++;
    if ({done, busy, mov_valid} !== 3'b110 || result !== t) begin
      errors++;
      $display("FAIL done_cycle got done/busy/mv=%b result=%h want 110 result=%h",
               {done, busy, mov_valid}, result, t);
    end
    tick;
    checks++;
    if ({done, busy, start_ready, mov_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL after_done got done/busy/ready/mv=%b want 0010", {done, busy, start_ready, mov_valid});
    end
  endtask

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    for (int h = 0; h < 4; h++) begin
      t[16 * h +: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0000;
    end
    return t;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick;
    checks++;
    if ({start_ready, busy, done, mov_valid, mov_fixed, mov_shamt, mov_clear, result} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 64'd0}) begin
      errors++;
      $display("FAIL reset_values got rdy=%b busy=%b done=%b mv=%b f=%h s=%0d c=%b r=%h want 1 0 0 0 0 0 0 0",
               start_ready, busy, done, mov_valid, mov_fixed, mov_shamt, mov_clear, result);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_directed;
    run_txn(64'hBA0962E10168F4C0, 1'b0, 64'd0);
    run_txn(64'hCAFE000000000000, 1'b0, 64'd0);
    run_txn(64'h0000000000000000, 1'b0, 64'd0);
    run_txn(64'hFFFFFFFFFFFFFFFF, 1'b0, 64'd0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) run_txn(rand_target(), 1'b0, 64'd0);
  endtask

  task automatic test_back_to_back;
    run_txn(64'h1, 1'b1, 64'h2);
    run_txn(64'h2, 1'b0, 64'd0);
    run_txn(rand_target(), 1'b1, 64'h0123_0000_4567_89AB);
    run_txn(64'h0123_0000_4567_89AB, 1'b0, 64'd0);
  endtask

  task automatic test_flush;
    bit seen_done;
    start_valid = 1'b1;
    target = 64'h1111_2222_3333_4444;
    tick;                       // N+1
    start_valid = 1'b0;
    checks++;
    if (mov_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_step0 got mv=%b want 1", mov_valid);
    end
    tick;                       // N+2
    flush = 1'b1;
    #1;
    checks++;
    if (start_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready_busy got %b want 0", start_ready);
    end
    tick;                       // N+3
    flush = 1'b0;
    #1;
    checks++;
    if ({mov_valid, busy, done, start_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL flush_abort got mv/busy/done/ready=%b want 0001", {mov_valid, busy, done, start_ready});
    end
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (done === 1'b1 || mov_valid === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_done got activity=%b want 0", seen_done);
    end
    // Flush while idle blocks acceptance.
    flush = 1'b1;
    start_valid = 1'b1;
    target = 64'hDEAD_BEEF_0000_0001;
    #1;
    checks++;
    if (start_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_ready got %b want 0", start_ready);
    end
    tick;
    checks++;
    if ({busy, mov_valid} !== 2'b00) begin
      errors++;
      $display("FAIL flush_idle_accept got busy/mv=%b want 00", {busy, mov_valid});
    end
    flush = 1'b0;
    start_valid = 1'b0;
    #1;
    run_txn(64'h8000_0001_0000_7FFF, 1'b0, 64'd0);
  endtask

  task automatic test_reset_mid;
    start_valid = 1'b1;
    target = 64'h0F0F_F0F0_1234_5678;
    tick;                       // N+1
    start_valid = 1'b0;
    tick;                       // N+2
    tick;                       // N+3
    reset = 1'b1;
    #1;
    checks++;
    if ({start_ready, busy, done, mov_valid, mov_fixed, mov_shamt, mov_clear, result} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 64'd0}) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b busy=%b done=%b mv=%b f=%h s=%0d c=%b r=%h want 1 0 0 0 0 0 0 0",
               start_ready, busy, done, mov_valid, mov_fixed, mov_shamt, mov_clear, result);
    end
    tick;
    tick;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold got busy/done=%b want 00", {busy, done});
    end
    reset = 1'b0;
    #1;
    run_txn(64'h0F0F_F0F0_1234_5678, 1'b0, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start_valid = 1'b0;
    flush = 1'b0;
    target = 64'd0;
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
